mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; all address and data widths SHALL be fixed at 16 bits.
REQ-002 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction-fetch request; held until accepted.
REQ-005 if_addr  in  16  word address of low half of 32-bit instruction.
REQ-006 if_ready  out  1  fetch accepted this cycle.
REQ-007 if_valid  out  1  one-cycle pulse; if_instr valid.
REQ-008 if_instr  out  32  {word@addr+1, word@addr}.
REQ-009 d_req  in  1  data request; held until accepted.
REQ-010 d_we  in  1  1=write, 0=read.
REQ-011 d_addr  in  16  data word address.
REQ-012 d_wdata  in  16  write data.
REQ-013 d_ready  out  1  data request accepted this cycle.
REQ-014 d_valid  out  1  one-cycle pulse; read data valid or write done.
REQ-015 d_rdata  out  16  read result.
REQ-016 mem_addr / mem_we / mem_wdata  out  16/1/16  single-port memory drive.
REQ-017 mem_rdata  in  16  memory read data; valid one cycle after mem_addr presented.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, FETCH_LO, FETCH_HI, FETCH_DONE, DATA_RD, DATA_CAP, DATA_WR.
REQ-020 if_ready/d_ready SHALL be combinational, asserted only in IDLE with rst=0 and the corresponding request high, never both in the same cycle.
REQ-021 On acceptance, address, d_we and d_wdata SHALL be latched; requester inputs are don't-care afterwards.
REQ-022 Fetch accepted at cycle N: FETCH_LO at N+1 drives mem_addr=addr; FETCH_HI at N+2 drives addr+1 and captures low word; FETCH_DONE at N+3 captures high word; if_valid=1 and state IDLE at N+4.
REQ-023 addr+1 SHALL wrap modulo 2^16 (0xFFFF -> 0x0000).
REQ-024 Data read accepted at N: DATA_RD at N+1 drives mem_addr; DATA_CAP at N+2 captures mem_rdata; d_valid=1 and state IDLE at N+3.
REQ-025 Data write accepted at N: DATA_WR at N+1 drives mem_addr, mem_wdata, mem_we=1; d_valid=1 and state IDLE at N+2.
REQ-026 mem_we SHALL be high only in DATA_WR; in IDLE mem_addr, mem_wdata SHALL be 0.
REQ-027 A fetch pair SHALL never be interleaved with a data access.
REQ-028 Both requests high in IDLE (fixed priority): data SHALL win.
REQ-029 A new request SHALL be acceptable in the same cycle a valid pulse is output.
REQ-030 if_instr and d_rdata SHALL hold their last value until overwritten.

Reset
REQ-031 With rst=1 at a clock edge: state=IDLE; if_valid, d_valid, busy=0; if_instr, d_rdata=0; last-grant flag=fetch.
REQ-032 Reset mid-operation SHALL abort the transaction with no valid pulse.
REQ-033 While rst=1, mem_we, if_ready, d_ready SHALL be forced 0 combinationally.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: on simultaneous requests, the requester not granted last SHALL win (alternating); undefined: fixed data priority per REQ-028, and the last-grant flag SHALL not be implemented.

Verification
REQ-035 Fetch if_addr=0x0010, mem[0x10]=0x1234, mem[0x11]=0xABCD -> if_ready at N, if_valid at N+4, if_instr=0xABCD1234.
REQ-036 Write d_addr=0x0200, d_wdata=0x5A5A, then read 0x0200 -> mem_we high exactly one cycle; d_valid at N+2; read d_rdata=0x5A5A at N'+3.
REQ-037 if_req and d_req held high 4 transactions -> without MEM_ARB_RR_EN grants D,D,D,D; with it grants D,F,D,F.
REQ-038 Fetch if_addr=0xFFFF -> mem_addr sequence 0xFFFF, 0x0000; if_instr={mem[0],mem[0xFFFF]}.
REQ-039 rst=1 during DATA_WR and during FETCH_HI -> mem_we=0 that cycle, no valid pulse, busy=0 and state IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its fetch/data requesters and the single-port memory.
// The arbiter takes the slave modport; the requester/memory side takes master.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;

  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [15:0] d_rdata;

  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_valid, if_instr, d_ready, d_valid, d_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_valid, if_instr, d_ready, d_valid, d_rdata,
           mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port 16-bit memory between a 32-bit instruction fetch and 16-bit data port.
// Define MEM_ARB_RR_EN for alternating grants on simultaneous requests; default is data priority.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    FETCH_DONE,
    DATA_RD,
    DATA_CAP,
    DATA_WR
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_lo;
  logic [31:0] r_if_instr;
  logic [15:0] r_d_rdata;
  logic        r_if_valid;
  logic        r_d_valid;

  logic        w_grant_d;
  logic        w_grant_f;
  logic [15:0] w_addr_inc;
  logic [15:0] w_mem_addr;
  logic [15:0] w_mem_wdata;
  logic        w_mem_we;

`ifdef MEM_ARB_RR_EN
  logic        r_last_d;  // 1 = data was granted last, 0 = fetch
`endif

  assign w_addr_inc = r_addr + 16'd1;

  always_comb begin
    w_grant_d = 1'b0;
    w_grant_f = 1'b0;
    if (r_state == IDLE && !rst) begin
`ifdef MEM_ARB_RR_EN
      if (bus.d_req && bus.if_req) begin
        w_grant_d = !r_last_d;
        w_grant_f = r_last_d;
      end else begin
        w_grant_d = bus.d_req;
        w_grant_f = bus.if_req;
      end
`else
      w_grant_d = bus.d_req;
      w_grant_f = bus.if_req && !bus.d_req;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt = r_state;
    w_mem_addr  = 16'h0000;
    w_mem_wdata = 16'h0000;
    w_mem_we    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // The read/write choice is latched by the state itself.
        if (w_grant_d)      w_state_nxt = bus.d_we ? DATA_WR : DATA_RD;
        else if (w_grant_f) w_state_nxt = FETCH_LO;
      end
      FETCH_LO: begin
        w_mem_addr  = r_addr;
        w_state_nxt = FETCH_HI;
      end
      FETCH_HI: begin
        w_mem_addr  = w_addr_inc;
        w_state_nxt = FETCH_DONE;
      end
      FETCH_DONE: w_state_nxt = IDLE;
      DATA_RD: begin
        w_mem_addr  = r_addr;
        w_state_nxt = DATA_CAP;
      end
      DATA_CAP: w_state_nxt = IDLE;
      DATA_WR: begin
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        w_mem_we    = !rst;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_instr <= 32'h0;
      r_d_rdata  <= 16'h0;
      r_lo       <= 16'h0;
    end else begin
      r_if_valid <= (r_state == FETCH_DONE);
      r_d_valid  <= (r_state == DATA_CAP) || (r_state == DATA_WR);
      if (r_state == FETCH_HI)   r_lo       <= bus.mem_rdata;
      if (r_state == FETCH_DONE) r_if_instr <= {bus.mem_rdata, r_lo};
      if (r_state == DATA_CAP)   r_d_rdata  <= bus.mem_rdata;
    end
  end

  // NOTE: request latches carry no reset; they are always loaded on a grant before being used.
  always_ff @(posedge clk) begin
    if (w_grant_d) begin
      r_addr  <= bus.d_addr;
      r_wdata <= bus.d_wdata;
    end else if (w_grant_f) begin
      r_addr  <= bus.if_addr;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)            r_last_d <= 1'b0;
    else if (w_grant_d) r_last_d <= 1'b1;
    else if (w_grant_f) r_last_d <= 1'b0;
  end
`endif

  assign bus.if_ready  = w_grant_f;
  assign bus.d_ready   = w_grant_d;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_valid   = r_d_valid;
  assign bus.if_instr  = r_if_instr;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of fetch/read/write transactions plus
// hand-written sequences for arbitration, back-to-back grants and mid-transaction reset.
module tb_mem_arbiter;

  typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad = 0;
  logic [15:0] mem [0:65535];
  logic [31:0] last_instr;
  logic [15:0] last_rdata;
  vec_t        vecs [9];

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Single-port memory model: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic txn(input kind_e kind, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [31:0] exp, input string name);
    int          want_lat;
    int          got_lat;
    int          we_cycles;
    logic        acc;
    logic        rdy;
    logic        vld;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] a_inc;
    want_lat = (kind == K_FETCH) ? 4 : (kind == K_READ) ? 3 : 2;
    @(negedge clk);
    if (kind == K_FETCH) begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = (kind == K_WRITE);
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      rdy = (kind == K_FETCH) ? bus.if_ready : bus.d_ready;
      if (rdy) acc = 1'b1;
      else     @(negedge clk);
    end
    check({name, "_accept"}, 32'(acc), 32'd1);
    got_lat   = 0;
    we_cycles = 0;
    a1        = 16'h0;
    a2        = 16'h0;
    for (int k = 1; k <= 8 && got_lat == 0; k++) begin
      @(negedge clk);
      // Scramble requester inputs: the arbiter must work from its latched copy.
      bus.if_req  = 1'b0;
      bus.d_req   = 1'b0;
      bus.if_addr = 16'hDEAD;
      bus.d_addr  = 16'hBEEF;
      bus.d_wdata = 16'hF00D;
      bus.d_we    = (kind != K_WRITE);
      #1;
      if (bus.mem_we) we_cycles++;
      if (k == 1) a1 = bus.mem_addr;
      if (k == 2) a2 = bus.mem_addr;
      vld = (kind == K_FETCH) ? bus.if_valid : bus.d_valid;
      if (vld) got_lat = k;
    end
    check({name, "_latency"}, 32'(got_lat), 32'(want_lat));
    check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({name, "_addr0"}, 32'(a1), 32'(addr));
    check({name, "_we_cycles"}, 32'(we_cycles), (kind == K_WRITE) ? 32'd1 : 32'd0);
    case (kind)
      K_FETCH: begin
        a_inc = addr + 16'd1;
        check({name, "_addr1"}, 32'(a2), 32'(a_inc));
        check({name, "_instr"}, bus.if_instr, exp);
        last_instr = exp;
        check({name, "_rdata_hold"}, 32'(bus.d_rdata), 32'(last_rdata));
      end
      K_READ: begin
        check({name, "_rdata"}, 32'(bus.d_rdata), 32'(exp[15:0]));
        last_rdata = exp[15:0];
        check({name, "_instr_hold"}, bus.if_instr, last_instr);
      end
      default: begin
        check({name, "_memory"}, 32'(mem[addr]), 32'(wdata));
        check({name, "_instr_hold"}, bus.if_instr, last_instr);
        check({name, "_rdata_hold"}, 32'(bus.d_rdata), 32'(last_rdata));
      end
    endcase
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && bus.busy; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  task automatic arb_seq();
    bit exp_d [4];
    int grants;
`ifdef MEM_ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0200;
    grants      = 0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      #1;
      check("arb_exclusive", 32'(bus.if_ready & bus.d_ready), 32'd0);
      if (bus.d_ready || bus.if_ready) begin
        check($sformatf("arb_grant%0d_is_data", grants), 32'(bus.d_ready), 32'(exp_d[grants]));
        if (grants > 0)
          check($sformatf("arb_grant%0d_b2b_valid", grants), 32'(bus.if_valid | bus.d_valid), 32'd1);
        grants++;
      end
      @(negedge clk);
    end
    check("arb_grant_count", 32'(grants), 32'd4);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    #1;
    wait_idle("arb_drain");
  endtask

  task automatic write_abort();
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0300;
    bus.d_wdata = 16'h7777;
    #1;
    check("wabort_accept", 32'(bus.d_ready), 32'd1);
    @(negedge clk);
    bus.d_req = 1'b0;
    rst       = 1'b1;
    #1;
    check("wabort_busy_in_wr", 32'(bus.busy), 32'd1);
    check("wabort_we_forced", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("wabort_busy_after", 32'(bus.busy), 32'd0);
    check("wabort_no_valid", 32'(bus.d_valid), 32'd0);
    @(negedge clk);
    #1;
    check("wabort_no_valid_late", 32'(bus.d_valid), 32'd0);
    check("wabort_memory_untouched", 32'(mem[16'h0300]), 32'd0);
  endtask

  task automatic fetch_abort();
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    #1;
    check("fabort_accept", 32'(bus.if_ready), 32'd1);
    @(negedge clk);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("fabort_hi_addr", 32'(bus.mem_addr), 32'h0011);
    check("fabort_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("fabort_busy_after", 32'(bus.busy), 32'd0);
    check("fabort_instr_cleared", bus.if_instr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fabort_no_valid%0d", i), 32'(bus.if_valid), 32'd0);
      @(negedge clk);
      #1;
    end
    last_instr = 32'h0;
    last_rdata = 16'h0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
    bus.if_req  = 1'b0;
    bus.if_addr = 16'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0;
    bus.d_wdata = 16'h0;
    last_instr  = 32'h0;
    last_rdata  = 16'h0;

    vecs[0] = '{K_WRITE, 16'h0010, 16'h1234, 32'h0};
    vecs[1] = '{K_WRITE, 16'h0011, 16'hABCD, 32'h0};
    vecs[2] = '{K_FETCH, 16'h0010, 16'h0000, 32'hABCD1234};
    vecs[3] = '{K_WRITE, 16'h0200, 16'h5A5A, 32'h0};
    vecs[4] = '{K_READ,  16'h0200, 16'h0000, 32'h00005A5A};
    vecs[5] = '{K_WRITE, 16'hFFFF, 16'h1111, 32'h0};
    vecs[6] = '{K_WRITE, 16'h0000, 16'h2222, 32'h0};
    vecs[7] = '{K_FETCH, 16'hFFFF, 16'h0000, 32'h22221111};
    vecs[8] = '{K_READ,  16'h0011, 16'h0000, 32'h0000ABCD};

    // Reset state, with both requests high to show the ready outputs are gated.
    repeat (3) @(negedge clk);
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #1;
    check("rst_if_ready", 32'(bus.if_ready), 32'd0);
    check("rst_d_ready", 32'(bus.d_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_d_valid", 32'(bus.d_valid), 32'd0);
    check("rst_if_instr", bus.if_instr, 32'h0);
    check("rst_d_rdata", 32'(bus.d_rdata), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      txn(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("v%0d", i));

    write_abort();
    fetch_abort();

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    arb_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
